// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per requester.
// The requester drives req and the access fields; the arbiter answers with a
// one-cycle gnt pulse, then a one-cycle valid pulse carrying rdata/err.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        valid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, sgn, addr, wdata,
    input  gnt, valid, err, rdata
  );

  modport slave (
    input  req, we, size, sgn, addr, wdata,
    output gnt, valid, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer in front of a single-cycle byte-addressed
// data memory. Requester A is the CPU load/store path, B the debug/loader.
// Each access takes IDLE/DONE -> ACCESS (gnt, memory driven) -> DONE (valid),
// so a continuously requesting port can complete every second cycle.
// Optional feature: define DMEM_ARB_BOUNDS_CHECK_EN to flag any access whose
// aligned word extends past MEM_BYTES as an error.
module dmem_arbiter #(
  parameter int MEM_BYTES    = 128,
  parameter bit RESET_PRIO_B = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave a,
  dmem_arbiter_if.slave b,
  output logic [31:0]   daddr,
  output logic [31:0]   dwdata,
  output logic [3:0]    we,
  input  logic [31:0]   drdata
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   prio_b;

  // Access context latched at grant time, consumed in ACCESS
  logic       port_p1;
  logic       st_p1;
  logic [1:0] size_p1;
  logic       sgn_p1;
  logic [1:0] lo_p1;
  logic       err_p1;

  logic        pick_a;
  logic        pick_b;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_sgn;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] sel_end;
  logic        sel_oob;
  logic        sel_err;

  // Half must sit on an even address, word on a multiple of four; size 3 is illegal
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = lo[0];
      2'd2:    r = (lo != 2'd0);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] r;
    case (size)
      2'd0:    r = 4'b0001 << lo;
      2'd1:    r = lo[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Store data is replicated across all lanes so byte enables alone pick the target
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{wd[7:0]}};
      2'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_data(input logic [1:0] size, input logic sgn,
                                            input logic [1:0] lo, input logic [31:0] rd);
    logic [7:0]  b8;
    logic [15:0] h16;
    logic [31:0] r;
    b8  = rd[8*lo +: 8];
    h16 = rd[16*lo[1] +: 16];
    case (size)
      2'd0:    r = sgn ? {{24{b8[7]}}, b8} : {24'd0, b8};
      2'd1:    r = sgn ? {{16{h16[15]}}, h16} : {16'd0, h16};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Round-robin winner selection and per-access checks on the winner's fields
  always_comb begin
    pick_a    = a.req && (!b.req || !prio_b);
    pick_b    = b.req && (!a.req || prio_b);
    sel_we    = pick_b ? b.we    : a.we;
    sel_size  = pick_b ? b.size  : a.size;
    sel_sgn   = pick_b ? b.sgn   : a.sgn;
    sel_addr  = pick_b ? b.addr  : a.addr;
    sel_wdata = pick_b ? b.wdata : a.wdata;
    sel_end   = {1'b0, sel_addr[31:2], 2'b00} + 33'd3;
    sel_oob   = (sel_end >= 33'(MEM_BYTES));
    sel_err   = misaligned(sel_size, sel_addr[1:0]) || (sel_oob && BOUNDS_EN);
  end

  // Sequencer FSM with registered grant, completion and memory-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      prio_b  <= RESET_PRIO_B;
      a.gnt   <= 1'b0;
      a.valid <= 1'b0;
      a.err   <= 1'b0;
      a.rdata <= 32'd0;
      b.gnt   <= 1'b0;
      b.valid <= 1'b0;
      b.err   <= 1'b0;
      b.rdata <= 32'd0;
      daddr   <= 32'd0;
      dwdata  <= 32'd0;
      we      <= 4'd0;
    end else begin
      a.gnt   <= 1'b0;
      b.gnt   <= 1'b0;
      a.valid <= 1'b0;
      b.valid <= 1'b0;
      daddr   <= 32'd0;
      dwdata  <= 32'd0;
      we      <= 4'd0;
      case (state)
        IDLE, DONE: begin
          if (pick_a || pick_b) begin
            state   <= ACCESS;
            port_p1 <= pick_b;
            st_p1   <= sel_we;
            size_p1 <= sel_size;
            sgn_p1  <= sel_sgn;
            lo_p1   <= sel_addr[1:0];
            err_p1  <= sel_err;
            a.gnt   <= pick_a;
            b.gnt   <= pick_b;
            daddr   <= sel_addr;
            dwdata  <= sel_we ? store_data(sel_size, sel_wdata) : 32'd0;
            we      <= (sel_we && !sel_err) ? byte_en(sel_size, sel_addr[1:0]) : 4'd0;
            if (a.req && b.req)
              prio_b <= pick_a;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (port_p1) begin
            b.valid <= 1'b1;
            b.err   <= err_p1;
            b.rdata <= (st_p1 || err_p1) ? 32'd0 : load_data(size_p1, sgn_p1, lo_p1, drdata);
          end else begin
            a.valid <= 1'b1;
            a.err   <= err_p1;
            a.rdata <= (st_p1 || err_p1) ? 32'd0 : load_data(size_p1, sgn_p1, lo_p1, drdata);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized single
// accesses, checked against a byte-array reference of the memory contents.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  dmem_arbiter_if ia ();
  dmem_arbiter_if ib ();

  dmem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .a      (ia),
    .b      (ib),
    .daddr  (daddr),
    .dwdata (dwdata),
    .we     (we),
    .drdata (drdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem     [128];
  logic [7:0]  ref_mem [128];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd  [2];
  logic        last_err [2];

  // Memory: combinational word read, byte-enabled write on the rising edge
  always_comb drdata = {mem[{daddr[6:2], 2'd3}], mem[{daddr[6:2], 2'd2}],
                        mem[{daddr[6:2], 2'd1}], mem[{daddr[6:2], 2'd0}]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[{daddr[6:2], i[1:0]}] <= dwdata[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] ad, input logic [1:0] sz);
    longint unsigned base;
    if (sz == 2'd3) return 1'b1;
    if ((ad % (32'd1 << sz)) != 0) return 1'b1;
    base = longint'(ad) - longint'(ad % 4);
    if (BOUNDS && (base + 3 >= 128)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] ad, input logic [1:0] sz);
    logic [3:0] m = 4'd0;
    for (int i = 0; i < (1 << sz); i++) m = m | (4'b0001 << ((ad % 4) + i));
    return m;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {4{wd[7:0]}};
    if (sz == 2'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] ad, input logic [1:0] sz,
                                           input logic sg);
    logic [31:0] v = 32'd0;
    logic [31:0] mask;
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[7'(ad + 32'(i))]) << (8 * i));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      if (sg && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[7'(ad + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  task automatic set_port(input bit p, input logic rq, input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] ad, input logic [31:0] wd);
    if (p) begin
      ib.req = rq; ib.we = w; ib.size = sz; ib.sgn = sg; ib.addr = ad; ib.wdata = wd;
    end else begin
      ia.req = rq; ia.we = w; ia.size = sz; ia.sgn = sg; ia.addr = ad; ia.wdata = wd;
    end
  endtask

  // One uncontended access on port p, checked from request to completion
  task automatic transact(input bit p, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd);
    int          n;
    logic        got;
    logic        e;
    logic [31:0] er;
    e  = ref_err(ad, sz);
    er = (w || e) ? 32'd0 : ref_load(ad, sz, sg);
    @(negedge clk);
    set_port(p, 1'b1, w, sz, sg, ad, wd);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = p ? ib.gnt : ia.gnt;
    end
    check("gnt_seen", 32'(got), 32'd1);
    check("gnt_latency", 32'(n), 32'd1);
    check("other_gnt", 32'(p ? ia.gnt : ib.gnt), 32'd0);
    check("acc_we", 32'(we), 32'((w && !e) ? ref_be(ad, sz) : 4'd0));
    if (!e) check("acc_daddr", daddr, ad);
    if (w && !e) check("acc_dwdata", dwdata, ref_wd(sz, wd));
    set_port(p, 1'b0, w, sz, sg, ad, wd);
    @(negedge clk);
    check("valid", 32'(p ? ib.valid : ia.valid), 32'd1);
    check("other_valid", 32'(p ? ia.valid : ib.valid), 32'd0);
    check("rdata", p ? ib.rdata : ia.rdata, er);
    check("err", 32'(p ? ib.err : ia.err), 32'(e));
    check("hold_rdata", p ? ia.rdata : ib.rdata, last_rd[!p]);
    check("hold_err", 32'(p ? ia.err : ib.err), 32'(last_err[!p]));
    check("done_we", 32'(we), 32'd0);
    if (w && !e) ref_store(ad, sz, wd);
    last_rd[p]  = er;
    last_err[p] = e;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_gnt"},   32'(ia.gnt),   32'd0);
    check({tag, "_a_valid"}, 32'(ia.valid), 32'd0);
    check({tag, "_a_err"},   32'(ia.err),   32'd0);
    check({tag, "_a_rdata"}, ia.rdata,      32'd0);
    check({tag, "_b_gnt"},   32'(ib.gnt),   32'd0);
    check({tag, "_b_valid"}, 32'(ib.valid), 32'd0);
    check({tag, "_b_err"},   32'(ib.err),   32'd0);
    check({tag, "_b_rdata"}, ib.rdata,      32'd0);
    check({tag, "_daddr"},   daddr,         32'd0);
    check({tag, "_dwdata"},  dwdata,        32'd0);
    check({tag, "_we"},      32'(we),       32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    last_err[0] = 1'b0; last_err[1] = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Both ports request together from reset and hold: strict A,B alternation
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h00, 32'd0);
    set_port(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rr_a_gnt_%0d", k), 32'(ia.gnt), 32'(k % 4 == 1));
      check($sformatf("rr_b_gnt_%0d", k), 32'(ib.gnt), 32'(k % 4 == 3));
      check($sformatf("rr_a_valid_%0d", k), 32'(ia.valid), 32'(k % 4 == 2));
      check($sformatf("rr_b_valid_%0d", k), 32'(ib.valid), 32'(k % 4 == 0));
      if (k % 4 == 2) check($sformatf("rr_a_rdata_%0d", k), ia.rdata, ref_load(32'h00, 2'd2, 1'b0));
      if (k % 4 == 0) check($sformatf("rr_b_rdata_%0d", k), ib.rdata, ref_load(32'h04, 2'd2, 1'b0));
    end
    ia.req = 1'b0;
    ib.req = 1'b0;
    last_rd[0] = ref_load(32'h00, 2'd2, 1'b0);
    last_rd[1] = ref_load(32'h04, 2'd2, 1'b0);

    // Word store then load
    transact(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    transact(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    // Byte store, signed and unsigned byte loads
    transact(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080);
    transact(1'b0, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    transact(1'b0, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    // Misaligned half store leaves memory untouched
    transact(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    transact(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000AAAA);
    transact(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    // Signed half load and illegal size
    transact(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    transact(1'b1, 1'b0, 2'd3, 1'b0, 32'h20, 32'd0);

    // Reset in the middle of a store's ACCESS cycle
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    check("mid_gnt", 32'(ia.gnt), 32'd1);
    check("mid_we", 32'(we), 32'hF);
    #1 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    ia.req = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst_hold");
    rst = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    last_err[0] = 1'b0; last_err[1] = 1'b0;
    transact(1'b0, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0);

    // Top-of-memory word
    transact(1'b1, 1'b0, 2'd2, 1'b0, 32'h7C, 32'd0);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    transact(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0);
    transact(1'b0, 1'b1, 2'd0, 1'b0, 32'h81, 32'h55);
`endif

    // Randomized single accesses on either port
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      transact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
               1'($urandom_range(0, 1)), ad, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequencer and two-port arbiter in front of the byte-addressed single-cycle data memory (32-bit word read, 4-bit byte-write-enable).
- Requester A is the CPU load/store path; requester B is the debug/loader port.
- Round-robin grant; one access in flight at a time.
- Per access: builds byte enables and replicated write data from size and address, checks alignment, and extracts and extends load data.

Parameters:
- MEM_BYTES, 128, data memory size in bytes; used only by the optional bounds check.
- RESET_PRIO_B, 0, initial round-robin priority after reset (0 = A favoured).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  A request; held with fields stable until a_gnt
- a_we  in  1  A: 1 = store, 0 = load
- a_size  in  2  A: 0 = byte, 1 = half, 2 = word, 3 = illegal
- a_signed  in  1  A: sign-extend load data (byte/half)
- a_addr  in  32  A byte address
- a_wdata  in  32  A store data, right-aligned
- a_gnt  out  1  A grant, one-cycle pulse
- a_valid  out  1  A completion, one-cycle pulse
- a_err  out  1  A error, qualified by a_valid
- a_rdata  out  32  A load data, qualified by a_valid
- b_req, b_we, b_size, b_signed, b_addr, b_wdata, b_gnt, b_valid, b_err, b_rdata: identical set for B
- daddr  out  32  memory byte address
- dwdata  out  32  memory write data
- we  out  4  memory byte write enables
- drdata  in  32  memory read data (combinational, word at daddr & ~3)

Behaviour:
- Reset: asynchronous, active-high on rst; clk as named. All outputs 0. State IDLE. Priority pointer = RESET_PRIO_B. An access interrupted by reset never writes: we is forced 0 immediately.
- States:
  - IDLE: if any req, latch winner's fields -> ACCESS.
  - ACCESS, 1 cycle: drive memory; x_gnt = 1; write commits at this cycle's closing edge; load data registered -> DONE.
  - DONE, 1 cycle: x_valid = 1 with x_rdata/x_err. Arbitrates exactly like IDLE (back-to-back accesses every 2 cycles); otherwise -> IDLE.
- Arbitration:
  - Single requester wins.
  - Both requesting: pointer holder wins; pointer then flips to the loser.
  - A requester still holding req during its own DONE is treated as a new request.
- Latency: req sampled at edge N; gnt in cycle N+1; valid in cycle N+2.
- Outside ACCESS: daddr = 0, dwdata = 0, we = 0.
- Store encoding (lo = addr[1:0]):
  - byte: we = 1 << lo; dwdata = {4{wdata[7:0]}}.
  - half: we = lo[1] ? 4'b1100 : 4'b0011; dwdata = {2{wdata[15:0]}}.
  - word: we = 4'b1111; dwdata = wdata.
- Misaligned or illegal access: half with lo[0] = 1, word with lo != 0, or size 3.
  - we = 0; rdata = 0; err = 1 at valid. The access still occupies ACCESS/DONE.
- Load extraction:
  - byte = drdata[8*lo +: 8].
  - half = drdata[16*lo[1] +: 16].
  - Extension: sign-extend if signed, else zero-extend. Word loads pass through.
- Stores return rdata = 0, err = 0 unless an error applies.
- x_rdata and x_err hold their value after valid until the next completion for that port.

Optional Feature:
- Macro DMEM_ARB_BOUNDS_CHECK_EN.
- Defined: an access whose aligned address + 3 >= MEM_BYTES is an error. Response: we = 0, rdata = 0, err = 1.
- Undefined: no range check; address passed through unchanged.

Test Plan:
- A stores word 0xDEADBEEF @0x10, then loads it -> we = 1111 in the write's ACCESS cycle; valid 2 cycles after req; a_rdata = 0xDEADBEEF.
- A stores byte 0x80 @0x13, then signed byte load @0x13 -> we = 1000, dwdata = 0x80808080; load rdata = 0xFFFFFF80 (unsigned: 0x00000080).
- A and B request together from reset, both held -> A granted first, B next; grants strictly alternate A, B, A, B at a 2-cycle spacing.
- Half store @0x21 -> err = 1, we never nonzero, memory @0x20 unchanged on readback.
- rst asserted mid-ACCESS of a store -> we drops to 0 asynchronously, no memory change, all outputs 0, state IDLE.
- With DMEM_ARB_BOUNDS_CHECK_EN, word load @0x7C -> ok; @0x80 -> err = 1, rdata = 0.
